// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC select for the fetch stage: hold, sequential +4, or word-aligned
// redirect target. When FETCH_ALIGN_CHECK_EN is defined it also flags a
// redirect target whose low two bits are non-zero.
module fetch_pc_next
  import fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_inc,
  input  logic        i_redirect,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        o_misaligned,
`endif
  output logic [31:0] o_next_pc
);

  // Redirect outranks the sequential step; low target bits are masked off.
  always_comb begin
    o_next_pc = i_pc;
    if (i_redirect) begin
      o_next_pc = i_redirect_pc & 32'hFFFF_FFFC;
    end else if (i_inc) begin
      o_next_pc = i_pc + PC_STEP;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign o_misaligned = |i_redirect_pc[1:0];
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from the instruction
// memory, and buffers one instruction for decode behind a valid/ready
// handshake. Branch/jump redirects override everything except reset.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned-redirect fault).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IM_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 pc_enable,
  input  logic [31:0]          instr_in,
  output logic [IM_ADDR_W-1:0] address_IM,
  output logic                 fetch_req,
  output logic [31:0]          instr_out,
  output logic [31:0]          pc_out,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 misalign_fault
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc_out;
  logic         r_valid;
  logic         r_fetch_req;
  logic [31:0]  w_next_pc;
  logic         w_inc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic         r_fault;
  logic         w_misaligned;
`endif

  // Advance the PC only when decode consumes the buffered instruction.
  assign w_inc = (r_state == HOLD) && instr_ready;

  fetch_pc_next u_pc_next (
    .i_pc          (r_pc),
    .i_redirect_pc (redirect_pc),
    .i_inc         (w_inc),
    .i_redirect    (redirect_valid),
`ifdef FETCH_ALIGN_CHECK_EN
    .o_misaligned  (w_misaligned),
`endif
    .o_next_pc     (w_next_pc)
  );

  // Fetch FSM, PC and one-entry instruction buffer; redirect wins over
  // any in-flight memory response or handshake.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_state     <= BOOT;
      r_pc        <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_pc_out    <= RESET_PC;
      r_valid     <= 1'b0;
      r_fetch_req <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_fault     <= 1'b0;
`endif
    end else if (redirect_valid) begin
      r_pc    <= w_next_pc;
      r_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (w_misaligned) begin
        r_state     <= FAULT;
        r_fault     <= 1'b1;
        r_fetch_req <= 1'b0;
      end else begin
        r_state     <= REQ;
        r_fault     <= 1'b0;
        r_fetch_req <= 1'b1;
      end
`else
      r_state     <= REQ;
      r_fetch_req <= 1'b1;
`endif
    end else begin
      case (r_state)
        BOOT: begin
          r_state     <= REQ;
          r_fetch_req <= 1'b1;
        end
        REQ: begin
          if (pc_enable) begin
            r_instr     <= instr_in;
            r_pc_out    <= r_pc;
            r_valid     <= 1'b1;
            r_fetch_req <= 1'b0;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            r_pc        <= w_next_pc;
            r_valid     <= 1'b0;
            r_fetch_req <= 1'b1;
            r_state     <= REQ;
          end
        end
        // FAULT is only left through an aligned redirect or reset.
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign address_IM  = r_pc[IM_ADDR_W+1:2];
  assign fetch_req   = r_fetch_req;
  assign instr_out   = r_instr;
  assign pc_out      = r_pc_out;
  assign instr_valid = r_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign_fault = r_fault;
`else
  assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          AW       = 5;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nRst = 1'b0;
  logic          pc_enable = 1'b0;
  logic [31:0]   instr_in = 32'h0;
  logic [AW-1:0] address_IM;
  logic          fetch_req;
  logic [31:0]   instr_out;
  logic [31:0]   pc_out;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          misalign_fault;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0 = just out of reset, 1 = waiting for memory,
  // 2 = holding a word for decode, 3 = faulted.
  logic [31:0] m_pc    = RESET_PC;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pcout = RESET_PC;
  int          m_phase = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .IM_ADDR_W(AW)) dut (
    .clk            (clk),
    .nRst           (nRst),
    .pc_enable      (pc_enable),
    .instr_in       (instr_in),
    .address_IM     (address_IM),
    .fetch_req      (fetch_req),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_fault (misalign_fault)
  );

  always #5 clk = ~clk;

  // One clock: step the model on the current inputs, then sample 1 time unit
  // after the rising edge.
  task automatic tick();
    logic [31:0] n_pc, n_instr, n_pcout;
    int n_phase;
    n_pc = m_pc; n_instr = m_instr; n_pcout = m_pcout; n_phase = m_phase;
    if (!nRst) begin
      n_pc = RESET_PC; n_instr = NOP; n_pcout = RESET_PC; n_phase = 0;
    end else if (redirect_valid) begin
      n_pc    = {redirect_pc[31:2], 2'b00};
      n_phase = (CHK && (redirect_pc[1:0] != 2'b00)) ? 3 : 1;
    end else if (m_phase == 0) begin
      n_phase = 1;
    end else if (m_phase == 1 && pc_enable) begin
      n_instr = instr_in; n_pcout = m_pc; n_phase = 2;
    end else if (m_phase == 2 && instr_ready) begin
      n_pc = m_pc + 32'd4; n_phase = 1;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pcout = n_pcout; m_phase = n_phase;
  endtask

  task automatic clear_inputs();
    pc_enable = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    clear_inputs();
    tick(); tick();
    n_tests++;
    if ({fetch_req, instr_valid, misalign_fault} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {fetch_req, instr_valid, misalign_fault});
    end
    n_tests++;
    if (instr_out !== NOP || pc_out !== RESET_PC) begin
      n_fail++; $display("FAIL reset_buffer: got instr %h pc %h expected %h %h", instr_out, pc_out, NOP, RESET_PC);
    end
    n_tests++;
    if (address_IM !== 5'd0) begin
      n_fail++; $display("FAIL reset_addr: got %0d expected 0", address_IM);
    end
    nRst = 1'b1;
    #2;
    n_tests++;
    if (fetch_req !== 1'b0) begin
      n_fail++; $display("FAIL boot_idle: got fetch_req %b expected 0", fetch_req);
    end
    tick();
    n_tests++;
    if (fetch_req !== 1'b1 || address_IM !== 5'd0) begin
      n_fail++; $display("FAIL first_req: got req %b addr %0d expected 1 0", fetch_req, address_IM);
    end
  endtask

  task automatic test_basic_fetch();
    pc_enable = 1'b1; instr_in = 32'h0050_0093;
    tick();
    pc_enable = 1'b0;
    n_tests++;
    if (instr_valid !== 1'b1 || instr_out !== 32'h0050_0093 || pc_out !== 32'h0 || fetch_req !== 1'b0) begin
      n_fail++; $display("FAIL basic_capture: got v %b instr %h pc %h req %b expected 1 00500093 0 0",
                         instr_valid, instr_out, pc_out, fetch_req);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_tests++;
    if (address_IM !== 5'd1 || fetch_req !== 1'b1 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_advance: got addr %0d req %b v %b expected 1 1 0", address_IM, fetch_req, instr_valid);
    end
  endtask

  task automatic test_stall();
    logic [31:0] word;
    word = $urandom();
    pc_enable = 1'b1; instr_in = word;
    tick();
    for (int i = 0; i < 3; i++) begin
      pc_enable = i[0] ? 1'b0 : 1'b1;
      instr_in  = $urandom();
      tick();
      n_tests++;
      if (instr_out !== word || pc_out !== 32'h4 || fetch_req !== 1'b0 || instr_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got instr %h pc %h req %b v %b expected %h 4 0 1",
                           i, instr_out, pc_out, fetch_req, instr_valid, word);
      end
    end
    pc_enable = 1'b0; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_tests++;
    if (address_IM !== 5'd2 || fetch_req !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: got addr %0d req %b expected 2 1", address_IM, fetch_req);
    end
  endtask

  task automatic test_redirect();
    pc_enable = 1'b1; instr_in = 32'hDEAD_BEEF;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    clear_inputs();
    n_tests++;
    if (instr_valid !== 1'b0 || address_IM !== 5'd16 || fetch_req !== 1'b1) begin
      n_fail++; $display("FAIL redirect_drop: got v %b addr %0d req %b expected 0 16 1", instr_valid, address_IM, fetch_req);
    end
    pc_enable = 1'b1; instr_in = 32'h0000_0033;
    tick();
    pc_enable = 1'b0;
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0020;
    tick();
    clear_inputs();
    n_tests++;
    if (address_IM !== 5'd8 || instr_valid !== 1'b0 || fetch_req !== 1'b1) begin
      n_fail++; $display("FAIL redirect_over_ready: got addr %0d v %b req %b expected 8 0 1", address_IM, instr_valid, fetch_req);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    n_tests++;
    if (address_IM !== 5'd31) begin
      n_fail++; $display("FAIL wrap_addr: got %0d expected 31", address_IM);
    end
    pc_enable = 1'b1; instr_in = 32'h1234_5678;
    tick();
    pc_enable = 1'b0;
    n_tests++;
    if (pc_out !== 32'hFFFF_FFFC || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap_pc_out: got %h v %b expected fffffffc 1", pc_out, instr_valid);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_tests++;
    if (address_IM !== 5'd0 || fetch_req !== 1'b1) begin
      n_fail++; $display("FAIL wrap_next: got addr %0d req %b expected 0 1", address_IM, fetch_req);
    end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0042;
    tick();
    clear_inputs();
    if (CHK) begin
      n_tests++;
      if (misalign_fault !== 1'b1 || fetch_req !== 1'b0 || instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL misalign_set: got f %b req %b v %b expected 1 0 0", misalign_fault, fetch_req, instr_valid);
      end
      pc_enable = 1'b1; instr_ready = 1'b1;
      tick();
      clear_inputs();
      n_tests++;
      if (misalign_fault !== 1'b1 || fetch_req !== 1'b0 || instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL misalign_sticky: got f %b req %b v %b expected 1 0 0", misalign_fault, fetch_req, instr_valid);
      end
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0008;
      tick();
      clear_inputs();
      n_tests++;
      if (misalign_fault !== 1'b0 || address_IM !== 5'd2 || fetch_req !== 1'b1) begin
        n_fail++; $display("FAIL misalign_clear: got f %b addr %0d req %b expected 0 2 1", misalign_fault, address_IM, fetch_req);
      end
    end else begin
      n_tests++;
      if (misalign_fault !== 1'b0 || address_IM !== 5'd16 || fetch_req !== 1'b1) begin
        n_fail++; $display("FAIL misalign_ignored: got f %b addr %0d req %b expected 0 16 1", misalign_fault, address_IM, fetch_req);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      nRst           = ($urandom_range(0, 63) != 0);
      pc_enable      = $urandom_range(0, 1) == 1;
      instr_ready    = $urandom_range(0, 1) == 1;
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = $urandom();
      if ($urandom_range(0, 1) == 1) redirect_pc[1:0] = 2'b00;
      instr_in       = $urandom();
      tick();
      n_tests++;
      if (fetch_req !== (m_phase == 1) || instr_valid !== (m_phase == 2) ||
          misalign_fault !== (m_phase == 3)) begin
        n_fail++; $display("FAIL rand_flags[%0d]: got req %b v %b f %b expected phase %0d", c, fetch_req, instr_valid, misalign_fault, m_phase);
      end
      if (m_phase != 3) begin
        n_tests++;
        if (address_IM !== m_pc[AW+1:2]) begin
          n_fail++; $display("FAIL rand_addr[%0d]: got %0d expected %0d", c, address_IM, m_pc[AW+1:2]);
        end
      end
      n_tests++;
      if (instr_out !== m_instr || pc_out !== m_pcout) begin
        n_fail++; $display("FAIL rand_buf[%0d]: got %h %h expected %h %h", c, instr_out, pc_out, m_instr, m_pcout);
      end
    end
    nRst = 1'b1;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect();
    test_wrap();
    test_misalign();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
